// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller and its datapath.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } mult_state_e;

    // Iteration counter width: one spare bit so the count can reach WIDTH without wrapping.
    function automatic int unsigned mult_cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Iteration counter for the multiplier controller: clear, increment, terminal-count flag.
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = mult_cnt_width(WIDTH);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Shift-add multiplier controller driving the ACC Load/Ad/Sh strobes.
// Optional feature: define MULT_CTRL_ABORT_EN to add the Abort input.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic St,
    input  logic M,
`ifdef MULT_CTRL_ABORT_EN
    input  logic Abort,
`endif
    output logic Load,
    output logic Ad,
    output logic Sh,
    output logic Busy,
    output logic Done
);

    mult_state_e r_state;
    mult_state_e w_state_nxt;
    logic        w_clr;
    logic        w_inc;
    logic        w_tc;
    logic        w_abort;

`ifdef MULT_CTRL_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif

    mult_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_tc_c  (w_tc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes are decoded straight from state (and M) so they drop the instant reset asserts.
    always_comb begin
        w_state_nxt = r_state;
        Load        = 1'b0;
        Ad          = 1'b0;
        Sh          = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (St) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                Busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    Load        = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                Busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (M) begin
                    Ad          = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    Sh          = 1'b1;
                    w_inc       = 1'b1;
                    w_state_nxt = w_tc ? ST_DONE : ST_ADD;
                end
            end
            ST_SHIFT: begin
                Busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    Sh          = 1'b1;
                    w_inc       = 1'b1;
                    w_state_nxt = w_tc ? ST_DONE : ST_ADD;
                end
            end
            ST_DONE: begin
                Done = 1'b1;
                if (!St) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: two instances (WIDTH=4 and WIDTH=32) each closing the loop through an ACC model.
module tb_mult_ctrl;

    localparam int unsigned W4  = 4;
    localparam int unsigned W32 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic st4, ld4, ad4, sh4, busy4, done4, abort4;
    logic st32, ld32, ad32, sh32, busy32, done32, abort32;
    logic [W4-1:0]  mc4, mp4;
    logic [W32-1:0] mc32, mp32;
    logic [2*W4:0]  acc4  = '0;
    logic [2*W32:0] acc32 = '0;

    int asserts = 0;
    int fails   = 0;
    int obs_q[$];
    int exp_q[$];
    bit got_done;
    bit done_busy_bad;
    logic [63:0] prod;

    mult_ctrl #(.WIDTH(W4)) dut4 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .St      (st4),
        .M       (acc4[0]),
`ifdef MULT_CTRL_ABORT_EN
        .Abort   (abort4),
`endif
        .Load    (ld4),
        .Ad      (ad4),
        .Sh      (sh4),
        .Busy    (busy4),
        .Done    (done4)
    );

    mult_ctrl #(.WIDTH(W32)) dut32 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .St      (st32),
        .M       (acc32[0]),
`ifdef MULT_CTRL_ABORT_EN
        .Abort   (abort32),
`endif
        .Load    (ld32),
        .Ad      (ad32),
        .Sh      (sh32),
        .Busy    (busy32),
        .Done    (done32)
    );

    // Accumulator models: {carry, upper half, multiplier half}
    always @(posedge clk) begin
        if (ld4)       acc4 <= {{(W4+1){1'b0}}, mp4};
        else if (ad4)  acc4 <= acc4 + ({{(W4+1){1'b0}}, mc4} << W4);
        else if (sh4)  acc4 <= acc4 >> 1;
        if (ld32)      acc32 <= {{(W32+1){1'b0}}, mp32};
        else if (ad32) acc32 <= acc32 + ({{(W32+1){1'b0}}, mc32} << W32);
        else if (sh32) acc32 <= acc32 >> 1;
    end

    // Reference: Load, then per multiplier bit (LSB first) an add+shift for 1 or a lone shift for 0.
    // Codes: 1=Load 2=Ad 3=Sh.
    task automatic build_exp(input int w, input logic [31:0] b);
        exp_q.delete();
        exp_q.push_back(1);
        for (int i = 0; i < w; i++) begin
            if (b[i]) exp_q.push_back(2);
            exp_q.push_back(3);
        end
    endtask

    // Starts one multiply and records one code per busy cycle until Done.
    // Codes: 0=no strobe, 4=several strobes, 5=Busy low before Done.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input bit hold_st);
        logic l, ad, s, d, bz;
        int code;
        obs_q.delete();
        got_done = 1'b0;
        done_busy_bad = 1'b0;
        @(negedge clk);
        if (w == 4) begin mc4 = a[3:0]; mp4 = b[3:0]; st4 = 1'b1; end
        else begin mc32 = a; mp32 = b; st32 = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!hold_st) begin st4 = 1'b0; st32 = 1'b0; end
            if (w == 4) begin l = ld4; ad = ad4; s = sh4; d = done4; bz = busy4; end
            else begin l = ld32; ad = ad32; s = sh32; d = done32; bz = busy32; end
            if (d) begin
                got_done = 1'b1;
                done_busy_bad = bz;
                break;
            end
            if (32'(l) + 32'(ad) + 32'(s) > 1) code = 4;
            else if (!bz) code = 5;
            else if (l)   code = 1;
            else if (ad)  code = 2;
            else if (s)   code = 3;
            else          code = 0;
            obs_q.push_back(code);
        end
        prod = (w == 4) ? 64'(acc4[2*W4-1:0]) : acc32[2*W32-1:0];
        if (!hold_st) @(negedge clk);
    endtask

    // Runs one multiply and checks trace, latency, Done/Busy and product against the model.
    task automatic check_op(input string name, input int w, input logic [31:0] a, input logic [31:0] b);
        bit seq_ok;
        int exp_lat;
        logic [63:0] exp_prod;
        logic [31:0] am, bm;
        am = (w == 4) ? {28'd0, a[3:0]} : a;
        bm = (w == 4) ? {28'd0, b[3:0]} : b;
        run_op(w, am, bm, 1'b0);
        build_exp(w, bm);
        exp_lat = 1 + w;
        for (int i = 0; i < w; i++) exp_lat += int'(bm[i]);
        exp_prod = 64'(am) * 64'(bm);
        asserts++;
        if (got_done !== 1'b1 || done_busy_bad !== 1'b0) begin
            fails++;
            $display("FAIL %s done: got_done=%0b busy_at_done=%0b required 1/0", name, got_done, done_busy_bad);
        end
        asserts++;
        if (obs_q.size() !== exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d required %0d", name, obs_q.size(), exp_lat);
        end
        seq_ok = (obs_q.size() == exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] != exp_q[i]) seq_ok = 1'b0;
        asserts++;
        if (seq_ok !== 1'b1) begin
            fails++;
            $display("FAIL %s strobe sequence: got %p required %p", name, obs_q, exp_q);
        end
        asserts++;
        if (prod !== exp_prod) begin
            fails++;
            $display("FAIL %s product: got %0d required %0d", name, prod, exp_prod);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        asserts++;
        if ({ld4, ad4, sh4, busy4, done4, ld32, ad32, sh32, busy32, done32} !== 10'd0) begin
            fails++;
            $display("FAIL reset outputs: got %b required 0", {ld4, ad4, sh4, busy4, done4, ld32, ad32, sh32, busy32, done32});
        end
        @(negedge clk);
        st4 = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        asserts++;
        if (ld4 !== 1'b1 || busy4 !== 1'b1) begin
            fails++;
            $display("FAIL reset first edge load: got ld=%0b busy=%0b required 1/1", ld4, busy4);
        end
        #1 rst_n = 1'b0;
        #1;
        asserts++;
        if ({ld4, busy4} !== 2'b00) begin
            fails++;
            $display("FAIL reset abandon: got %b required 00", {ld4, busy4});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        check_op("w4_1011", 4, 32'd5, 32'b1011);
        check_op("w4_zero", 4, 32'd9, 32'd0);
        check_op("w4_ones", 4, 32'd15, 32'd15);
        check_op("w32_7x200", 32, 32'd200, 32'd7);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) check_op("w4_rand", 4, $urandom, $urandom);
        for (int i = 0; i < 3; i++)  check_op("w32_rand", 32, $urandom, $urandom);
    endtask

    task automatic test_st_hold();
        bit ok;
        run_op(4, 32'd3, 32'd6, 1'b1);
        asserts++;
        if (got_done !== 1'b1) begin
            fails++;
            $display("FAIL hold reach done: got %0b required 1", got_done);
        end
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done4 !== 1'b1 || ld4 !== 1'b0 || busy4 !== 1'b0) ok = 1'b0;
        end
        asserts++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL hold stays done: got done=%0b ld=%0b required done held, no load", done4, ld4);
        end
        st4 = 1'b0;
        @(negedge clk);
        st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        asserts++;
        if (ld4 !== 1'b1) begin
            fails++;
            $display("FAIL hold restart load: got %0b required 1", ld4);
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done4) ok = 1'b1;
        end
        asserts++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL hold restart done: got %0b required 1", ok);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int nsh;
        bit ok;
        nsh = 0;
        @(negedge clk);
        mp4 = 4'd0; mc4 = 4'd7; st4 = 1'b1;
        for (int i = 0; i < 20 && nsh < 3; i++) begin
            @(negedge clk);
            st4 = 1'b0;
            if (sh4) nsh++;
        end
        asserts++;
        if (nsh !== 3) begin
            fails++;
            $display("FAIL midreset reach third shift: got %0d required 3", nsh);
        end
        #1 rst_n = 1'b0;
        #1;
        asserts++;
        if ({ld4, ad4, sh4, busy4, done4} !== 5'd0) begin
            fails++;
            $display("FAIL midreset outputs: got %b required 0", {ld4, ad4, sh4, busy4, done4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({ld4, ad4, sh4, busy4, done4} !== 5'd0) ok = 1'b0;
        end
        asserts++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL midreset idle after release: got %b required 0", {ld4, ad4, sh4, busy4, done4});
        end
    endtask

`ifdef MULT_CTRL_ABORT_EN
    task automatic test_abort();
        bit seen, ok;
        seen = 1'b0;
        @(negedge clk);
        mp4 = 4'b0110; mc4 = 4'd3; st4 = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            st4 = 1'b0;
            if (ad4) seen = 1'b1;
        end
        asserts++;
        if (seen !== 1'b1) begin
            fails++;
            $display("FAIL abort reach add: got %0b required 1", seen);
        end
        abort4 = 1'b1;
        #1;
        asserts++;
        if ({ld4, ad4, sh4} !== 3'd0) begin
            fails++;
            $display("FAIL abort strobes: got %b required 000", {ld4, ad4, sh4});
        end
        @(negedge clk);
        abort4 = 1'b0;
        asserts++;
        if (busy4 !== 1'b0) begin
            fails++;
            $display("FAIL abort idle: got busy=%0b required 0", busy4);
        end
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({ld4, ad4, sh4, done4} !== 4'd0) ok = 1'b0;
        end
        asserts++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL abort quiet: got %b required 0", {ld4, ad4, sh4, done4});
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        st4 = 1'b0; st32 = 1'b0; abort4 = 1'b0; abort32 = 1'b0;
        mc4 = '0; mp4 = '0; mc32 = '0; mp32 = '0;
        test_reset();
        test_directed();
        test_random();
        test_st_hold();
        test_reset_mid();
`ifdef MULT_CTRL_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
